// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a single-cycle register port,
// with a prescaled tick and a registered level interrupt to the core.
module mtimer #(
  parameter int unsigned DIV = 10,
  parameter int unsigned PW  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_intr
);

  localparam int unsigned TW = 64;
  localparam int unsigned DW = 32;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;

  logic [TW-1:0] mtime_q, mtime_d;
  logic [TW-1:0] mtimecmp_q, mtimecmp_d;
  logic          count_en_q, count_en_d;
  logic          intr_en_q, intr_en_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] hi_shadow_q, hi_shadow_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          timer_intr_q, timer_intr_d;

  logic [2:0]    word;
  logic          tick;
  logic          unused_addr_lsb;

  assign word            = req_addr[4:2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign tick            = count_en_q && (pre_q == PRE_LAST);

  // Next-state: prescaler and tick first, register writes override the tick.
  always_comb begin
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    count_en_d   = count_en_q;
    intr_en_d    = intr_en_q;
    pre_d        = pre_q;
    hi_shadow_d  = hi_shadow_q;
    resp_valid_d = req_valid;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    timer_intr_d = intr_en_q && (mtime_q >= mtimecmp_q);

    if (count_en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
    if (tick) begin
      mtime_d = mtime_q + TW'(1);
    end

    if (req_valid) begin
      unique case (word)
        A_MTIME_LO: begin
          if (req_we) begin
            mtime_d = {mtime_q[63:32], req_wdata};
          end else begin
            resp_rdata_d = mtime_q[31:0];
            hi_shadow_d  = mtime_q[63:32];
          end
        end
        A_MTIME_HI: begin
          if (req_we) mtime_d = {req_wdata, mtime_q[31:0]};
          else        resp_rdata_d = hi_shadow_q;
        end
        A_CMP_LO: begin
          if (req_we) mtimecmp_d = {mtimecmp_q[63:32], req_wdata};
          else        resp_rdata_d = mtimecmp_q[31:0];
        end
        A_CMP_HI: begin
          if (req_we) mtimecmp_d = {req_wdata, mtimecmp_q[31:0]};
          else        resp_rdata_d = mtimecmp_q[63:32];
        end
        A_CTRL: begin
          if (req_we) begin
            count_en_d = req_wdata[0];
            intr_en_d  = req_wdata[1];
            pre_d      = '0;
          end else begin
            resp_rdata_d = {30'd0, intr_en_q, count_en_q};
          end
        end
        default: resp_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      count_en_q   <= 1'b0;
      intr_en_q    <= 1'b0;
      pre_q        <= '0;
      hi_shadow_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      timer_intr_q <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      count_en_q   <= count_en_d;
      intr_en_q    <= intr_en_d;
      pre_q        <= pre_d;
      hi_shadow_q  <= hi_shadow_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      timer_intr_q <= timer_intr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign timer_intr = timer_intr_q;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: requests push expected responses into a
// scoreboard that a negedge monitor drains and compares.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        timer_intr;

  mtimer #(.DIV(10), .PW(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .timer_intr (timer_intr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One request; the response is expected exactly one cycle later.
  task automatic req(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    e.cyc   = cyc + 1;
    e.addr  = addr;
    e.rdata = erd;
    e.err   = eerr;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got resp_valid=1, required no response (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("resp_cycle@0x%02h", mon_e.addr), 32'(cyc), 32'(mon_e.cyc));
          check($sformatf("rdata@0x%02h", mon_e.addr), resp_rdata, mon_e.rdata);
          check($sformatf("err@0x%02h", mon_e.addr), 32'(resp_err), 32'(mon_e.err));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        n_checks++;
        $display("FAIL missing_resp@0x%02h: got resp_valid=0, required 1 (cycle %0d)", mon_e.addr, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  int e0, f0, g0, h0;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_timer_intr", 32'(timer_intr), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset values of every mapped register
    req(1'b0, 5'h00, 32'd0, 32'h0000_0000, 1'b0);
    req(1'b0, 5'h04, 32'd0, 32'h0000_0000, 1'b0);
    req(1'b0, 5'h08, 32'd0, 32'hFFFF_FFFF, 1'b0);
    req(1'b0, 5'h0C, 32'd0, 32'hFFFF_FFFF, 1'b0);
    req(1'b0, 5'h10, 32'd0, 32'h0000_0000, 1'b0);
    check("intr_after_reset", 32'(timer_intr), 32'd0);

    // Count to mtimecmp=5 with DIV=10: mtime hits 5 fifty cycles after ctrl write
    req(1'b1, 5'h10, 32'h3, 32'd0, 1'b0);
    e0 = cyc;
    req(1'b1, 5'h0C, 32'h0, 32'd0, 1'b0);
    req(1'b1, 5'h08, 32'h5, 32'd0, 1'b0);
    wait_until(e0 + 50);
    check("intr_before_match", 32'(timer_intr), 32'd0);
    req(1'b0, 5'h00, 32'd0, 32'h5, 1'b0);
    check("intr_on_match", 32'(timer_intr), 32'd1);

    // Raising mtimecmp drops the interrupt two cycles after the request
    req(1'b1, 5'h08, 32'hFFFF_FFFF, 32'd0, 1'b0);
    f0 = cyc;
    check("intr_1cyc_after_cmp_write", 32'(timer_intr), 32'd1);
    @(posedge clk); #1;
    check("intr_2cyc_after_cmp_write", 32'(timer_intr), 32'd0);

    // Lo-to-hi carry and hi shadow coherence
    req(1'b1, 5'h10, 32'h0, 32'd0, 1'b0);
    req(1'b1, 5'h04, 32'h0, 32'd0, 1'b0);
    req(1'b1, 5'h00, 32'hFFFF_FFF0, 32'd0, 1'b0);
    req(1'b1, 5'h10, 32'h1, 32'd0, 1'b0);
    g0 = cyc;
    wait_until(g0 + 160);
    req(1'b0, 5'h00, 32'd0, 32'h0000_0000, 1'b0);
    req(1'b0, 5'h04, 32'd0, 32'h0000_0001, 1'b0);
    req(1'b1, 5'h10, 32'h0, 32'd0, 1'b0);
    req(1'b1, 5'h04, 32'h55, 32'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    req(1'b0, 5'h04, 32'd0, 32'h0000_0001, 1'b0);
    req(1'b0, 5'h00, 32'd0, 32'h0000_0000, 1'b0);
    req(1'b0, 5'h04, 32'd0, 32'h0000_0055, 1'b0);
    check("intr_disabled", 32'(timer_intr), 32'd0);

    // Write to mtime lo lands on a tick cycle; tick must be dropped
    req(1'b1, 5'h10, 32'h1, 32'd0, 1'b0);
    h0 = cyc;
    wait_until(h0 + 9);
    req(1'b1, 5'h00, 32'h1234, 32'd0, 1'b0);
    req(1'b1, 5'h10, 32'h0, 32'd0, 1'b0);
    req(1'b0, 5'h00, 32'd0, 32'h0000_1234, 1'b0);
    req(1'b0, 5'h04, 32'd0, 32'h0000_0055, 1'b0);

    // Unmapped addresses back to back, then ctrl readback masks upper bits
    req(1'b0, 5'h14, 32'd0, 32'd0, 1'b1);
    req(1'b1, 5'h18, 32'hDEAD_BEEF, 32'd0, 1'b1);
    req(1'b0, 5'h1C, 32'd0, 32'd0, 1'b1);
    req(1'b1, 5'h10, 32'hFFFF_FFFF, 32'd0, 1'b0);
    req(1'b0, 5'h10, 32'd0, 32'h0000_0003, 1'b0);
    check("intr_enabled_mtime_above_cmp", 32'(timer_intr), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
